// File: rtl/periodo_pkg.sv
// periodo_pkg: shared timing constants and FSM states for the period generator
package periodo_pkg;
  localparam int CLK_POR_US = 50;
  localparam int PERIODO_MIN_US = 2;
  localparam int PERIODO_MAX_US = 1000;
  localparam int ANCHO_PRE = 6;
  localparam logic [ANCHO_PRE-1:0] PRE_FIN = ANCHO_PRE'(CLK_POR_US - 1);
  typedef enum logic [1:0] {IDLE, ALTO, BAJO} estado_t;
endpackage

// File: rtl/prescaler_us.sv
// prescaler_us: divides clock_FPGA down to a one-cycle tick per microsecond
module prescaler_us
  import periodo_pkg::*;
(
  input  logic clock_FPGA,
  input  logic reset,
  input  logic limpiar,
  output logic tick
);
  logic [ANCHO_PRE-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == PRE_FIN;
  // wrap at terminal count; a clear realigns the microsecond grid to the caller
  always_comb cnt_d = (limpiar || tick) ? '0 : cnt_q + 1'b1;
  // count register
  always_ff @(posedge clock_FPGA) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/generador_periodo.sv
// generador_periodo: square wave with a microsecond-programmed period, updated only at period boundaries
module generador_periodo
  import periodo_pkg::*;
#(
  parameter int ANCHO = 12
) (
  input  logic             clock_FPGA,
  input  logic             reset,
  input  logic [ANCHO-1:0] periodo_us,
  input  logic             cargar,
  input  logic             habilitar,
  output logic             onda,
  output logic             pulso_flanco,
  output logic [ANCHO-1:0] periodo_activo,
  output logic             error_periodo
);
  estado_t estado_q, estado_d;
  logic [ANCHO-1:0] us_q, us_d, activo_q, activo_d, pend_q, pend_d, alto, bajo, mitad;
  logic pend_f_q, pend_f_d, onda_q, flanco_q, error_q;
  logic tick, limpiar, valido, fin_mitad, fin_bajo, carga_pend;
  prescaler_us u_pre (
    .clock_FPGA(clock_FPGA),
    .reset(reset),
    .limpiar(limpiar),
    .tick(tick)
  );
  assign valido = periodo_us >= ANCHO'(PERIODO_MIN_US) && periodo_us <= ANCHO'(PERIODO_MAX_US);
  assign alto = activo_q >> 1;
  assign bajo = activo_q - alto;
  assign mitad = (estado_q == ALTO) ? alto : bajo;
  assign fin_mitad = tick && (us_q == mitad - 1'b1);
  assign fin_bajo = (estado_q == BAJO) && fin_mitad;
  assign carga_pend = cargar && valido && (estado_q != IDLE);
  assign limpiar = estado_d != estado_q;
  // next state: a started period always runs to the end of its low half
  always_comb begin
    estado_d = estado_q;
    if (estado_q == IDLE) estado_d = (habilitar && activo_q != '0) ? ALTO : IDLE;
    else if (fin_mitad) estado_d = (estado_q == ALTO) ? BAJO : (habilitar ? ALTO : IDLE);
  end
  // half-period counter plus active/pending period registers; boundary consumes old pending before a same-cycle load
  always_comb begin
    us_d = (limpiar || estado_q == IDLE) ? '0 : us_q + ANCHO'(tick);
    activo_d = (cargar && valido && estado_q == IDLE) ? periodo_us : (fin_bajo && pend_f_q) ? pend_q : activo_q;
    pend_d = carga_pend ? periodo_us : pend_q;
    pend_f_d = carga_pend ? 1'b1 : fin_bajo ? 1'b0 : pend_f_q;
  end
  // state, counters and registered outputs
  always_ff @(posedge clock_FPGA) begin
    if (reset) begin
      estado_q <= IDLE;
      us_q <= '0;
      activo_q <= '0;
      pend_q <= '0;
      pend_f_q <= 1'b0;
      onda_q <= 1'b0;
      flanco_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      us_q <= us_d;
      activo_q <= activo_d;
      pend_q <= pend_d;
      pend_f_q <= pend_f_d;
      onda_q <= estado_d == ALTO;
      flanco_q <= (estado_d == ALTO) && (estado_q != ALTO);
      error_q <= cargar && !valido;
    end
  end
  assign onda = onda_q;
  assign pulso_flanco = flanco_q;
  assign periodo_activo = activo_q;
  assign error_periodo = error_q;
endmodule
